// File: rtl/wb_bus_arbiter_if.sv
// Wishbone bundle between the requesting masters, the round-robin arbiter and
// the single shared slave port. The master modport is the bench-side agent and slave model.
interface wb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8
);
    logic [NUM_MASTERS-1:0]            m_cyc_i;
    logic [NUM_MASTERS-1:0]            m_stb_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
    logic [DATA_WIDTH-1:0]             m_dat_o;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            m_err_o;
    logic                              s_cyc_o;
    logic                              s_stb_o;
    logic                              s_we_o;
    logic [ADDR_WIDTH-1:0]             s_adr_o;
    logic [DATA_WIDTH-1:0]             s_dat_o;
    logic [DATA_WIDTH-1:0]             s_dat_i;
    logic                              s_ack_i;
    logic [NUM_MASTERS-1:0]            gnt_o;
    logic                              busy_o;

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
               gnt_o, busy_o
    );

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
               gnt_o, busy_o
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS requesters share one slave port,
// with a watchdog that aborts a strobe the slave never acknowledges.
module wb_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT     = 16
) (
    input logic             clk_i,
    input logic             rst_i,
    wb_bus_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            err_q, err_d;
    logic [IW-1:0]   pick, cand;
    logic            any_req;
    logic            g_cyc, in_grant, drive;

    // last_q doubles as the index of the current grant once we leave IDLE
    assign g_cyc    = bus.m_cyc_i[last_q];
    assign in_grant = (state_q == GRANT);
    assign drive    = in_grant & g_cyc;

    assign bus.s_cyc_o = drive;
    assign bus.s_stb_o = drive & bus.m_stb_i[last_q];
    assign bus.s_we_o  = drive & bus.m_we_i[last_q];
    assign bus.s_adr_o = drive ? ADDR_WIDTH'(bus.m_adr_i >> (int'(last_q) * ADDR_WIDTH)) : '0;
    assign bus.s_dat_o = drive ? DATA_WIDTH'(bus.m_dat_i >> (int'(last_q) * DATA_WIDTH)) : '0;
    assign bus.m_dat_o = in_grant ? bus.s_dat_i : '0;
    assign bus.m_ack_o = in_grant ? (NUM_MASTERS'(bus.s_ack_i) << last_q) : '0;
    assign bus.m_err_o = err_q ? (NUM_MASTERS'(1) << last_q) : '0;
    assign bus.gnt_o   = (state_q != IDLE) ? (NUM_MASTERS'(1) << last_q) : '0;
    assign bus.busy_o  = (state_q != IDLE);

    // First requester strictly after the previous grant, wrapping around
    always_comb begin
        pick    = last_q;
        cand    = last_q;
        any_req = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = IW'((int'(last_q) + i) % NUM_MASTERS);
            if (!any_req && bus.m_cyc_i[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (any_req) begin
                    state_d = GRANT;
                    last_d  = pick;
                end
            end
            GRANT: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    wd_d    = '0;
                end else if (bus.s_ack_i) begin
                    wd_d = '0;
                end else if (bus.s_stb_o && TIMEOUT > 0) begin
                    // An ack on the final stall cycle takes the branch above, so ack wins
                    if (wd_q == WD_LAST) begin
                        state_d = ABORT;
                        err_d   = 1'b1;
                        wd_d    = '0;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            ABORT: begin
                wd_d = '0;
                if (!g_cyc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_MASTERS - 1);
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: stimulus pushes expected acks/errors into a
// scoreboard queue and a negedge monitor pops them as the DUT responds.
module tb_wb_bus_arbiter;
    localparam int NM = 2;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct {
        logic          err;
        int            m;
        logic [DW-1:0] rdata;
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] wdat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    wb_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input int m, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        bus.m_cyc_i[m] = 1'b1;
        bus.m_stb_i[m] = 1'b1;
        bus.m_we_i[m]  = we;
        bus.m_adr_i[m*AW +: AW] = adr;
        bus.m_dat_i[m*DW +: DW] = dat;
    endtask

    task automatic drop(input int m);
        bus.m_cyc_i[m] = 1'b0;
        bus.m_stb_i[m] = 1'b0;
        bus.m_we_i[m]  = 1'b0;
        bus.m_adr_i[m*AW +: AW] = '0;
        bus.m_dat_i[m*DW +: DW] = '0;
    endtask

    task automatic push(input logic err, input int m, input logic [DW-1:0] rdata,
                        input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] wdat);
        exp_t e;
        e.err = err; e.m = m; e.rdata = rdata; e.adr = adr; e.we = we; e.wdat = wdat;
        sb.push_back(e);
    endtask

    task automatic ack_beat(input logic [DW-1:0] rd);
        bus.s_dat_i = rd;
        bus.s_ack_i = 1'b1;
        tick(1);
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;
    endtask

    // Bounded wait for gnt_o to select master m; records the edge count taken
    task automatic wait_gnt(input int m, input int exp_cyc, input string name);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (n < 8 && !ok) begin
            tick(1);
            n++;
            if (bus.gnt_o == (NM'(1) << m)) ok = 1'b1;
        end
        check({name, "_gnt_lat"}, ok ? n : -1, exp_cyc);
    endtask

    task automatic pair(input int first);
        int second;
        second = 1 - first;
        req(0, 1'b1, 2'd1, 8'h11);
        req(1, 1'b1, 2'd3, 8'h22);
        wait_gnt(first, 1, "pair_first");
        push(1'b0, first, 8'h00, (first == 0) ? 2'd1 : 2'd3, 1'b1, (first == 0) ? 8'h11 : 8'h22);
        tick(1);
        ack_beat(8'h00);
        drop(first);
        wait_gnt(second, 2, "pair_second");
        push(1'b0, second, 8'h00, (second == 0) ? 2'd1 : 2'd3, 1'b1, (second == 0) ? 8'h11 : 8'h22);
        ack_beat(8'h00);
        drop(second);
        tick(1);
        check("pair_idle_busy", bus.busy_o, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ((|bus.m_ack_o) || (|bus.m_err_o))) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {bus.m_err_o, bus.m_ack_o}, 0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.err) begin
                    check("err_vec", bus.m_err_o, 32'(1) << mon_e.m);
                    check("err_noack", bus.m_ack_o, 0);
                    check("err_scyc", bus.s_cyc_o, 0);
                end else begin
                    check("ack_vec", bus.m_ack_o, 32'(1) << mon_e.m);
                    check("ack_noerr", bus.m_err_o, 0);
                    check("ack_rdata", bus.m_dat_o, mon_e.rdata);
                    check("ack_adr", bus.s_adr_o, mon_e.adr);
                    check("ack_we", bus.s_we_o, mon_e.we);
                    check("ack_wdat", bus.s_dat_o, mon_e.wdat);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

    initial begin
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0;
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 8'hFF;
        tick(2);
        check("rst_gnt", bus.gnt_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_scyc", bus.s_cyc_o, 0);
        check("rst_sstb", bus.s_stb_o, 0);
        check("rst_ack", bus.m_ack_o, 0);
        check("rst_err", bus.m_err_o, 0);
        check("rst_mdat", bus.m_dat_o, 0);
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;
        rst_n = 1'b1;
        tick(1);

        // Contention straight after reset: m0 first
        pair(0);

        // Single master write, ack two cycles after grant
        req(0, 1'b1, 2'd2, 8'hA5);
        check("single_pre_cyc", bus.s_cyc_o, 0);
        wait_gnt(0, 1, "single");
        check("single_cyc", bus.s_cyc_o, 1);
        check("single_adr", bus.s_adr_o, 2);
        check("single_dat", bus.s_dat_o, 8'hA5);
        check("single_we", bus.s_we_o, 1);
        push(1'b0, 0, 8'h00, 2'd2, 1'b1, 8'hA5);
        tick(1);
        ack_beat(8'h00);
        drop(0);
        tick(1);
        check("single_idle_gnt", bus.gnt_o, 0);
        check("single_idle_busy", bus.busy_o, 0);

        // last grant was m0, so m1 wins the next tie
        pair(1);

        // Read routing to m1
        req(1, 1'b0, 2'd1, 8'h00);
        wait_gnt(1, 1, "read");
        push(1'b0, 1, 8'h3C, 2'd1, 1'b0, 8'h00);
        tick(1);
        ack_beat(8'h3C);
        drop(1);
        tick(1);

        // Timeout: slave never acks m0; m1 waits meanwhile
        req(0, 1'b1, 2'd0, 8'h5A);
        wait_gnt(0, 1, "to");
        push(1'b1, 0, 8'h00, 2'd0, 1'b0, 8'h00);
        req(1, 1'b0, 2'd2, 8'h00);
        for (int k = 1; k <= TO - 1; k++) begin
            tick(1);
            check("to_noerr", bus.m_err_o, 0);
            check("to_cyc_held", bus.s_cyc_o, 1);
        end
        tick(1);
        check("to_abort_cyc", bus.s_cyc_o, 0);
        check("to_abort_gnt", bus.gnt_o, 1);
        check("to_abort_busy", bus.busy_o, 1);
        tick(1);
        check("to_err_once", bus.m_err_o, 0);
        check("to_abort_cyc2", bus.s_cyc_o, 0);
        drop(0);
        wait_gnt(1, 2, "to_next");
        push(1'b0, 1, 8'h77, 2'd2, 1'b0, 8'h00);
        ack_beat(8'h77);
        drop(1);
        tick(1);

        // Ack lands on exactly the last stall cycle: no error
        req(0, 1'b1, 2'd3, 8'hC3);
        wait_gnt(0, 1, "bnd");
        tick(TO - 1);
        push(1'b0, 0, 8'h00, 2'd3, 1'b1, 8'hC3);
        ack_beat(8'h00);
        check("bnd_cyc", bus.s_cyc_o, 1);
        check("bnd_noerr", bus.m_err_o, 0);
        tick(1);
        check("bnd_noerr2", bus.m_err_o, 0);
        drop(0);
        tick(1);

        // Reset while m1 holds the bus with a strobe pending
        req(1, 1'b1, 2'd1, 8'h99);
        wait_gnt(1, 1, "rst");
        #2;
        rst_n = 1'b0;
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 8'hEE;
        #1;
        check("mid_rst_gnt", bus.gnt_o, 0);
        check("mid_rst_busy", bus.busy_o, 0);
        check("mid_rst_scyc", bus.s_cyc_o, 0);
        check("mid_rst_sstb", bus.s_stb_o, 0);
        check("mid_rst_swe", bus.s_we_o, 0);
        check("mid_rst_sadr", bus.s_adr_o, 0);
        check("mid_rst_sdat", bus.s_dat_o, 0);
        check("mid_rst_ack", bus.m_ack_o, 0);
        check("mid_rst_mdat", bus.m_dat_o, 0);
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;
        req(0, 1'b0, 2'd0, 8'h00);
        tick(1);
        rst_n = 1'b1;
        wait_gnt(0, 1, "post_rst");
        push(1'b0, 0, 8'h42, 2'd0, 1'b0, 8'h00);
        tick(1);
        ack_beat(8'h42);
        drop(0);
        wait_gnt(1, 2, "post_rst_m1");
        push(1'b0, 1, 8'h00, 2'd1, 1'b1, 8'h99);
        ack_beat(8'h00);
        drop(1);
        tick(2);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone slave port (the I2C controller register file) between NUM_MASTERS requesters, e.g. a test sequencer and an interrupt-service agent.
- Owns the slave-side cyc/stb/we/adr/dat drive.
- Routes ack/read data back to the granted master only.
- Aborts a hung cycle via a timeout watchdog.
- Sits between the bench-side Wishbone master agents and the DUT slave port.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- ADDR_WIDTH, 2, Wishbone address width
- DATA_WIDTH, 8, Wishbone data width
- TIMEOUT, 16, max cycles a granted strobe may wait for ack; 0 disables watchdog

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data, same packing
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master timeout error pulse
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i  in  1  slave ack
- gnt_o  out  NUM_MASTERS  one-hot current grant (all zero when idle)
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i low, async): state=IDLE, gnt_o=0, last_gnt=NUM_MASTERS-1, watchdog=0. All outputs 0 (s_* zero, m_ack_o/m_err_o zero, m_dat_o zero). Applies immediately mid-transaction; the slave cycle is dropped with no ack delivered.
- States: IDLE, GRANT, ABORT.
- IDLE:
  - If any m_cyc_i set: pick the first requester searching from last_gnt+1 upward with wrap modulo NUM_MASTERS.
  - Register gnt_o one-hot, set last_gnt, go to GRANT.
  - Latency: request at edge N, s_cyc_o visible after edge N+1.
- GRANT:
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o are a combinational mux of granted master g, gated by m_cyc_i[g].
  - m_ack_o[g]=s_ack_i; all other m_ack_o bits 0.
  - m_dat_o=s_dat_i while in GRANT, else 0.
  - Grant held for the whole cycle, including multiple stb/ack beats under one cyc (no preemption).
  - m_cyc_i[g] sampled low -> IDLE. This gives one mandatory idle cycle between grants.
- Watchdog (TIMEOUT>0):
  - Counter increments each GRANT cycle with s_stb_o=1 and s_ack_i=0.
  - Clears on s_ack_i or on leaving GRANT.
  - On reaching TIMEOUT: m_err_o[g]=1 for exactly one cycle, registered, on the cycle after the count hits TIMEOUT; go to ABORT.
- ABORT: s_cyc_o=s_stb_o=0, m_ack_o=0. gnt_o stays on g. Wait for m_cyc_i[g]=0, then IDLE.
- Simultaneous events:
  - s_ack_i on the same cycle the count would reach TIMEOUT -> ack wins; no error.
  - Requests arriving while GRANT/ABORT are held until IDLE.
  - Requester dropping cyc before being granted is simply not selected.
- Fairness: with all masters requesting continuously, grant order is 0,1,...,N-1,0,...

Test Plan:
- Single master: m0 writes adr=2 dat=0xA5, slave acks 2 cycles later -> s_cyc_o rises 1 cycle after m_cyc_i[0]; s_adr_o=2, s_dat_o=0xA5, s_we_o=1; m_ack_o=01; gnt_o=01; returns to IDLE after cyc drops.
- Contention: m0 and m1 request on the same edge after reset -> m0 granted first; m1 granted on the 2nd cycle after m0 drops cyc; next simultaneous request grants m1 before m0 only if last_gnt=0.
- Read routing: m1 reads adr=1, slave returns 0x3C with ack -> m_dat_o=0x3C and m_ack_o=10; m_ack_o[0] stays 0 throughout.
- Timeout: m0 strobes, slave never acks, TIMEOUT=16 -> m_err_o[0] pulses once after 16 stalled cycles; s_cyc_o low from the next cycle; state returns to IDLE when m0 drops cyc; m1 then granted.
- Ack at the boundary: slave acks on exactly the 16th stall cycle -> m_ack_o[0]=1 and m_err_o never asserts.
- Reset mid-cycle: assert rst_i low while m1 is granted with stb pending -> all outputs 0 asynchronously, gnt_o=0. After release with both masters requesting, m0 is granted first.
